uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Receive-side command parser sitting directly downstream of the UART top block's RX outputs (`o_rx_data`/`o_rx_valid`). It consumes ASCII bytes typed on the host terminal and assembles a fixed number of hexadecimal digits into one command word. On a line terminator it presents that word to the sequencer front end over a valid/ready handshake. Malformed lines are discarded, flagged with a one-cycle error strobe and counted.

## Interface
- `NUM_NIB`, default 2: hex digits per command; `DATA_W = 4*NUM_NIB` (derived localparam, not overridable).
- `clk`, in, 1: clock; all logic on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `i_rx_data`, in, 8: received ASCII byte; sampled only when `i_rx_valid` is high.
- `i_rx_valid`, in, 1: one-cycle strobe per received byte.
- `o_cmd_data`, out, DATA_W: assembled command; first digit received is the most significant nibble.
- `o_cmd_valid`, out, 1: command available; held until accepted.
- `i_cmd_ready`, in, 1: downstream accepts when `o_cmd_valid & i_cmd_ready`.
- `o_err_stb`, out, 1: one-cycle pulse per rejected line or dropped byte.
- `o_err_cnt`, out, 8: saturating count of `o_err_stb` pulses; saturates at 8'hFF.

## Operation
- Reset values: state stIdle, `o_cmd_data` 0, `o_cmd_valid` 0, `o_err_stb` 0, `o_err_cnt` 0, nibble count 0.
- Character classes:
  - Hex digit: '0'-'9', 'A'-'F' (lowercase handled per Configuration).
  - Terminator: 8'h0D (CR) or 8'h0A (LF).
  - Other: every remaining byte value.
- stIdle: no digits held.
  - Hex digit: shift into the accumulator, count = 1, go to stCollect.
  - Terminator: ignored, so CR/LF pairs and blank lines are harmless.
  - Other: go to stError.
- stCollect:
  - Hex digit with count < NUM_NIB: shift it in (`acc <= {acc, nib}`) and increment count.
  - Hex digit with count == NUM_NIB: go to stError (line too long).
  - Terminator with count == NUM_NIB: load `o_cmd_data` from the accumulator, assert `o_cmd_valid`, go to stOut.
  - Terminator with count < NUM_NIB: pulse `o_err_stb`, go to stIdle.
  - Other: go to stError.
- stError: entered with a single `o_err_stb` pulse. Discards all bytes until a terminator arrives, then goes to stIdle. No further pulses are generated while in this state.
- stOut: `o_cmd_valid` high and `o_cmd_data` stable.
  - On `i_cmd_ready`: deassert valid, clear count, go to stIdle.
  - Any byte arriving while in stOut is dropped and pulses `o_err_stb` (overrun).
  - If a byte arrives in the same cycle as the handshake, the byte is dropped as an overrun and the handshake still completes.
- Error counter: increments on each `o_err_stb` pulse, saturating at 8'hFF; it never wraps.
- Reset mid-line or mid-handshake: the partial line is lost, `o_cmd_valid` drops in the next cycle, and the counter clears.

## Timing
- `o_cmd_valid` rises on the clock edge that samples the terminator byte; latency is 1 cycle from the terminator's `i_rx_valid`.
- `o_err_stb` is registered and high for exactly the one cycle after the offending byte is sampled.
- `o_err_cnt` updates in the same cycle that `o_err_stb` is high.
- Downstream may hold `i_cmd_ready` low indefinitely; `o_cmd_data` holds its value.
- Back-to-back commands: the next valid line can complete no sooner than the cycle after acceptance.
- Throughput: one byte per cycle is supported in every state, well above the UART byte rate.

## Configuration
- `UART_CMD_PARSER_LOWERCASE_EN` defined: 'a'-'f' are classified as hex digits with values A-F.
- Undefined: 'a'-'f' are class Other, so a line containing them is rejected through stError.

## Test plan
- NUM_NIB=2. Send "3F\r", `i_cmd_ready` held high: `o_cmd_valid` high for 1 cycle with `o_cmd_data`=8'h3F, `o_err_cnt` stays 0.
- Send "A5\r\n", with `i_cmd_ready` held low for 20 cycles and then raised:
  - `o_cmd_data`=8'hA5 stays stable throughout.
  - The LF arrives while valid is held, so it is dropped as an overrun and gives 1 `o_err_stb`.
  - Exactly one handshake occurs.
- Send "7\r", then "123\r", then "G1\r": three `o_err_stb` pulses, `o_err_cnt`=3, no `o_cmd_valid`; the next line "01\r" yields 8'h01.
- Send "ff\r": with the macro defined, the command is 8'hFF; without it, one error pulse and no command.
- Send 300 lines of "Z\r": `o_err_cnt` saturates at 8'hFF.
- Send "4" then "2", assert `rst` for 1 cycle, then send "\r": no command is issued and all outputs read their reset values.

Source files
------------

// File: rtl/uart_cmd_parser_if.sv
// Handshake bundle between the UART RX outputs, the command parser and the sequencer front end.
// The parser takes the master modport; the surrounding logic takes the slave modport.
interface uart_cmd_parser_if #(
  parameter int NUM_NIB = 2
);
  localparam int DATA_W = 4 * NUM_NIB;

  logic [7:0]        i_rx_data;
  logic              i_rx_valid;
  logic [DATA_W-1:0] o_cmd_data;
  logic              o_cmd_valid;
  logic              i_cmd_ready;
  logic              o_err_stb;
  logic [7:0]        o_err_cnt;

  modport master (
    input  i_rx_data, i_rx_valid, i_cmd_ready,
    output o_cmd_data, o_cmd_valid, o_err_stb, o_err_cnt
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_cmd_ready,
    input  o_cmd_data, o_cmd_valid, o_err_stb, o_err_cnt
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Assembles NUM_NIB ASCII hex digits into a command word, released on CR/LF over valid/ready.
// Define UART_CMD_PARSER_LOWERCASE_EN to also accept 'a'-'f' as hex digits.
module uart_cmd_parser #(
  parameter int NUM_NIB = 2
) (
  input  logic               clk,
  input  logic               rst,
  uart_cmd_parser_if.master  bus
);
  localparam int DATA_W = 4 * NUM_NIB;
  localparam int CNT_W  = $clog2(NUM_NIB + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_NIB);

  typedef enum logic [1:0] {stIdle, stCollect, stError, stOut} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] acc, acc_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] cmd_data, cmd_data_n;
  logic              cmd_valid, cmd_valid_n;
  logic              err_stb, err_n;
  logic [7:0]        err_cnt, err_cnt_n;
  logic              is_hex, is_term;
  logic [3:0]        nib;

  always_comb begin
    is_hex  = 1'b0;
    nib     = 4'h0;
    is_term = (bus.i_rx_data == 8'h0D) || (bus.i_rx_data == 8'h0A);
    if (bus.i_rx_data >= 8'h30 && bus.i_rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = bus.i_rx_data[3:0];
    end else if (bus.i_rx_data >= 8'h41 && bus.i_rx_data <= 8'h46) begin
      is_hex = 1'b1;
      nib    = bus.i_rx_data[3:0] + 4'd9;
`ifdef UART_CMD_PARSER_LOWERCASE_EN
    end else if (bus.i_rx_data >= 8'h61 && bus.i_rx_data <= 8'h66) begin
      is_hex = 1'b1;
      nib    = bus.i_rx_data[3:0] + 4'd9;
`else
    end else begin
      is_hex = 1'b0;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    cmd_data_n  = cmd_data;
    cmd_valid_n = cmd_valid;
    err_n       = 1'b0;
    case (state)
      stIdle: begin
        if (bus.i_rx_valid) begin
          if (is_hex) begin
            acc_n   = (acc << 4) | DATA_W'(nib);
            cnt_n   = CNT_W'(1);
            state_n = stCollect;
          end else if (!is_term) begin
            err_n   = 1'b1;
            state_n = stError;
          end
        end
      end
      stCollect: begin
        if (bus.i_rx_valid) begin
          if (is_hex) begin
            if (cnt == CNT_FULL) begin
              err_n   = 1'b1;
              state_n = stError;
            end else begin
              acc_n = (acc << 4) | DATA_W'(nib);
              cnt_n = cnt + CNT_W'(1);
            end
          end else if (is_term) begin
            if (cnt == CNT_FULL) begin
              cmd_data_n  = acc;
              cmd_valid_n = 1'b1;
              state_n     = stOut;
            end else begin
              err_n   = 1'b1;
              cnt_n   = '0;
              state_n = stIdle;
            end
          end else begin
            err_n   = 1'b1;
            state_n = stError;
          end
        end
      end
      stError: begin
        // Only one pulse was issued on entry; the rest of the line is swallowed silently.
        if (bus.i_rx_valid && is_term) begin
          cnt_n   = '0;
          state_n = stIdle;
        end
      end
      stOut: begin
        if (bus.i_cmd_ready) begin
          cmd_valid_n = 1'b0;
          cnt_n       = '0;
          state_n     = stIdle;
        end
        if (bus.i_rx_valid) err_n = 1'b1;
      end
      default: state_n = stIdle;
    endcase
    err_cnt_n = (err_n && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= stIdle;
      acc       <= '0;
      cnt       <= '0;
      cmd_data  <= '0;
      cmd_valid <= 1'b0;
      err_stb   <= 1'b0;
      err_cnt   <= 8'h00;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      cmd_data  <= cmd_data_n;
      cmd_valid <= cmd_valid_n;
      err_stb   <= err_n;
      err_cnt   <= err_cnt_n;
    end
  end

  assign bus.o_cmd_data  = cmd_data;
  assign bus.o_cmd_valid = cmd_valid;
  assign bus.o_err_stb   = err_stb;
  assign bus.o_err_cnt   = err_cnt;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: table of lines, scoreboard of expected commands,
// plus hand-written sequences for backpressure, overrun, saturation and reset.
module tb_uart_cmd_parser;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_cmd_parser_if #(.NUM_NIB(2)) bus ();

  uart_cmd_parser #(.NUM_NIB(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [47:0] text;
    int          len;
    bit          has_cmd;
    logic [7:0]  cmd;
    int          errs;
  } vec_t;

  vec_t       vecs [10];
  logic [7:0] exp_q [$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         exp_err     = 0;
  int         exp_pulses  = 0;
  int         exp_hs      = 0;
  int         seen_pulses = 0;
  int         hs_count    = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic addErrors(input int n);
    exp_pulses += n;
    exp_err    += n;
    if (exp_err > 255) exp_err = 255;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.has_cmd) begin
      exp_q.push_back(v.cmd);
      exp_hs++;
    end
    for (int i = 0; i < v.len; i++) sendByte(v.text[8*(v.len-1-i) +: 8]);
    addErrors(v.errs);
    idle(4);
  endtask

  // Scoreboard: every accepted command must match the oldest expected word.
  always @(negedge clk) begin
    if (bus.o_err_stb) seen_pulses++;
    if (bus.o_cmd_valid && bus.i_cmd_ready) begin
      hs_count++;
      if (exp_q.size() == 0) checkOutput("unexpected_cmd", 32'(bus.o_cmd_data), 32'hFFFF_FFFF);
      else checkOutput("cmd_data", 32'(bus.o_cmd_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    vec_t zline;
    int   hs_before;

    vecs[0] = '{"3F\r",     3, 1'b1, 8'h3F, 0};
    vecs[1] = '{"7\r",      2, 1'b0, 8'h00, 1};
    vecs[2] = '{"123\r",    4, 1'b0, 8'h00, 1};
    vecs[3] = '{"G1\r",     3, 1'b0, 8'h00, 1};
    vecs[4] = '{"01\r",     3, 1'b1, 8'h01, 0};
`ifdef UART_CMD_PARSER_LOWERCASE_EN
    vecs[5] = '{"ff\r",     3, 1'b1, 8'hFF, 0};
`else
    vecs[5] = '{"ff\r",     3, 1'b0, 8'h00, 1};
`endif
    vecs[6] = '{"\r\n",     2, 1'b0, 8'h00, 0};
    vecs[7] = '{"12x\r",    4, 1'b0, 8'h00, 1};
    vecs[8] = '{"AB\n",     3, 1'b1, 8'hAB, 0};
    vecs[9] = '{"E\r\rD0\r", 6, 1'b1, 8'hD0, 1};
    zline   = '{"Z\r",      2, 1'b0, 8'h00, 1};

    bus.i_rx_data   = 8'h00;
    bus.i_rx_valid  = 1'b0;
    bus.i_cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    checkOutput("rst_cmd_data",  32'(bus.o_cmd_data),  32'h0);
    checkOutput("rst_cmd_valid", 32'(bus.o_cmd_valid), 32'h0);
    checkOutput("rst_err_stb",   32'(bus.o_err_stb),   32'h0);
    checkOutput("rst_err_cnt",   32'(bus.o_err_cnt),   32'h0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      checkOutput("err_cnt",     32'(bus.o_err_cnt),   32'(exp_err));
      checkOutput("cmd_pending", 32'(exp_q.size()),    32'h0);
      checkOutput("valid_idle",  32'(bus.o_cmd_valid), 32'h0);
    end
    checkOutput("handshakes", 32'(hs_count), 32'(exp_hs));

    // Backpressure: A5 held for 20 cycles, trailing LF is an overrun.
    $display("[TB] backpressure sequence");
    hs_before       = hs_count;
    bus.i_cmd_ready = 1'b0;
    exp_q.push_back(8'hA5);
    sendByte(8'h41);
    sendByte(8'h35);
    sendByte(8'h0D);
    sendByte(8'h0A);
    addErrors(1);
    for (int i = 0; i < 20; i++) begin
      checkOutput("hold_data",  32'(bus.o_cmd_data),  32'hA5);
      checkOutput("hold_valid", 32'(bus.o_cmd_valid), 32'h1);
      idle(1);
    end
    bus.i_cmd_ready = 1'b1;
    idle(3);
    checkOutput("bp_handshakes", 32'(hs_count - hs_before), 32'h1);
    checkOutput("bp_err_cnt",    32'(bus.o_err_cnt),        32'(exp_err));
    checkOutput("bp_valid",      32'(bus.o_cmd_valid),      32'h0);

    // Byte arriving in the same cycle as the handshake is still an overrun.
    hs_before       = hs_count;
    bus.i_cmd_ready = 1'b0;
    exp_q.push_back(8'h55);
    sendByte(8'h35);
    sendByte(8'h35);
    sendByte(8'h0D);
    idle(3);
    bus.i_cmd_ready = 1'b1;
    sendByte(8'h51);
    addErrors(1);
    idle(3);
    checkOutput("ov_handshakes", 32'(hs_count - hs_before), 32'h1);
    checkOutput("ov_err_cnt",    32'(bus.o_err_cnt),        32'(exp_err));
    checkOutput("ov_valid",      32'(bus.o_cmd_valid),      32'h0);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) applyStimulus(zline);
    checkOutput("sat_err_cnt", 32'(bus.o_err_cnt),  32'hFF);
    checkOutput("err_pulses",  32'(seen_pulses),    32'(exp_pulses));
    checkOutput("sat_queue",   32'(exp_q.size()),   32'h0);

    // Reset in the middle of a line.
    sendByte(8'h34);
    sendByte(8'h32);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    exp_err = 0;
    sendByte(8'h0D);
    idle(3);
    checkOutput("mid_rst_cmd_data",  32'(bus.o_cmd_data),  32'h0);
    checkOutput("mid_rst_cmd_valid", 32'(bus.o_cmd_valid), 32'h0);
    checkOutput("mid_rst_err_stb",   32'(bus.o_err_stb),   32'h0);
    checkOutput("mid_rst_err_cnt",   32'(bus.o_err_cnt),   32'h0);

    applyStimulus(vecs[4]);
    checkOutput("post_rst_queue", 32'(exp_q.size()), 32'h0);
    checkOutput("final_hs",       32'(hs_count),     32'(exp_hs + 2));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
